// File: rtl/timer_irq_unit.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) driving the CP0 hardware interrupt.
// Optional prescaler: define TIMER_PRESCALE_EN to add parameter PRESCALE.
module timer_irq_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h00007F00,
    parameter int unsigned WIDTH     = 32
`ifdef TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE  = 4
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INTR} state_t;

    state_t           state;
    logic             ctrl_en;
    logic [1:0]       ctrl_mode;
    logic             ctrl_im;
    logic [WIDTH-1:0] preset;
    logic [WIDTH-1:0] count;
    logic             irq_flag;
    logic             pulse_pending;

    logic             hit;
    logic [1:0]       sel;
    logic             ctrl_wr;
    logic             preset_wr;
    logic             adv;
    logic             unused_bits;

    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign sel         = addr[3:2];
    assign ctrl_wr     = hit && we && (sel == 2'd0);
    assign preset_wr   = hit && we && (sel == 2'd1);
    assign unused_bits = ^{addr[1:0], din};

`ifdef TIMER_PRESCALE_EN
    localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PSC_W-1:0] psc;

    assign adv = (psc == PSC_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc <= '0;
        end else if (state == LOAD || adv) begin
            psc <= '0;
        end else begin
            psc <= psc + PSC_W'(1);
        end
    end
`else
    assign adv = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ctrl_en       <= 1'b0;
            ctrl_mode     <= 2'd0;
            ctrl_im       <= 1'b0;
            preset        <= '0;
            count         <= '0;
            irq_flag      <= 1'b0;
            pulse_pending <= 1'b0;
        end else begin
            if (preset_wr)
                preset <= din[WIDTH-1:0];

            if (pulse_pending || ctrl_wr) begin
                irq_flag      <= 1'b0;
                pulse_pending <= 1'b0;
            end

            case (state)
                IDLE: if (ctrl_en) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl_en) begin
                        state <= IDLE;
                    end else if (adv) begin
                        if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end else begin
                            count <= '0;
                            state <= INTR;
                        end
                    end
                end
                INTR: begin
                    irq_flag <= 1'b1;
                    if (ctrl_mode == 2'd1) begin
                        pulse_pending <= 1'b1;
                        state         <= LOAD;
                    end else begin
                        ctrl_en <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Placed after the FSM so a same-edge CTRL store overrides the one-shot EN clear.
            if (ctrl_wr) begin
                ctrl_en   <= din[0];
                ctrl_mode <= din[2:1];
                ctrl_im   <= din[3];
            end
        end
    end

    always_comb begin
        dout = '0;
        if (hit) begin
            case (sel)
                2'd0:    dout = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
                2'd1:    dout = 32'(preset);
                2'd2:    dout = 32'(count);
                default: dout = '0;
            endcase
        end
    end

    assign irq = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_irq_unit.sv
// Scoreboard bench for timer_irq_unit: timed expectations are queued with the stimulus
// and checked on the cycle they fall due.
module tb_timer_irq_unit;

    localparam logic [31:0] B = 32'h00007F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int          cyc;
        bit          is_irq;
        logic [31:0] a;
        logic [31:0] v;
        string       tag;
    } exp_t;

    exp_t sb[$];

    timer_irq_unit dut (
        .clk  (clk),
        .reset(reset),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic exp_rd(input int c, input logic [31:0] a, input logic [31:0] v, input string tag);
        exp_t e;
        e.cyc = c; e.is_irq = 1'b0; e.a = a; e.v = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic exp_irq(input int c, input logic v, input string tag);
        exp_t e;
        e.cyc = c; e.is_irq = 1'b1; e.a = '0; e.v = {31'd0, v}; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic service();
        int i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc <= cyc) begin
                exp_t e;
                e = sb[i];
                sb.delete(i);
                if (e.is_irq) begin
                    check(e.tag, {31'd0, irq}, e.v);
                end else begin
                    addr = e.a;
                    #1;
                    check(e.tag, dout, e.v);
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        we = 1'b0;
        service();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; din = d; we = 1'b1;
        tick();
    endtask

    initial begin
        int e0;
        int e1;
        int w;
        reset = 1'b0; we = 1'b0; addr = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        addr = B;     #1; check("rst_ctrl", dout, 32'd0);
        addr = B + 4; #1; check("rst_preset", dout, 32'd0);
        addr = B + 8; #1; check("rst_count", dout, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        #3 reset = 1'b1;

`ifndef TIMER_PRESCALE_EN
        // One-shot, PRESET=5
        wr(B + 4, 32'd5);
        e0 = cyc + 1;
        for (int k = 0; k < 6; k++) exp_rd(e0 + 2 + k, B + 8, 32'(5 - k), "os_count");
        exp_irq(e0 + 7, 1'b0, "os_irq_early");
        exp_irq(e0 + 8, 1'b1, "os_irq_rise");
        exp_irq(e0 + 9, 1'b1, "os_irq_hold");
        exp_rd(e0 + 8, B, 32'h8, "os_ctrl_en_clr");
        wr(B, 32'h9);
        run(9);
        w = cyc + 1;
        exp_irq(w, 1'b0, "os_irq_clear");
        wr(B, 32'h0);

        // Auto-reload, PRESET=3
        wr(B + 4, 32'd3);
        e0 = cyc + 1;
        exp_irq(e0 + 5, 1'b0, "ar_pre");
        exp_irq(e0 + 6, 1'b1, "ar_pulse1");
        exp_irq(e0 + 7, 1'b0, "ar_drop1");
        exp_irq(e0 + 10, 1'b0, "ar_gap");
        exp_irq(e0 + 11, 1'b1, "ar_pulse2");
        exp_irq(e0 + 12, 1'b0, "ar_drop2");
        wr(B, 32'hB);
        run(12);
        w = cyc + 1;
        exp_rd(w + 2, B + 8, 32'd2, "ar_stop_hold");
        exp_irq(w + 3, 1'b0, "ar_stop_irq");
        wr(B, 32'h0);
        run(3);

        // Mask and address decode
        wr(B + 4, 32'd2);
        e0 = cyc + 1;
        for (int k = 1; k <= 8; k++) exp_irq(e0 + k, 1'b0, "mask_irq");
        exp_rd(e0 + 3, B + 8, 32'd1, "ro_count");
        exp_rd(e0 + 6, B, 32'd0, "mask_ctrl");
        exp_rd(e0 + 6, B + 12, 32'd0, "rd_slot3");
        exp_rd(e0 + 6, B + 16, 32'd0, "rd_miss16");
        exp_rd(e0 + 6, B + 20, 32'd0, "rd_miss20");
        exp_rd(e0 + 6, B + 5, 32'd2, "rd_bytealign");
        wr(B, 32'h1);
        run(2);
        wr(B + 8, 32'd123);
        run(5);

        // Disable mid-count, then re-enable
        wr(B + 4, 32'd10);
        e0 = cyc + 1;
        exp_rd(e0 + 2, B + 8, 32'd10, "dis_load");
        exp_rd(e0 + 5, B + 8, 32'd7, "dis_at7");
        for (int k = 6; k <= 9; k++) begin
            exp_rd(e0 + k, B + 8, 32'd7, "dis_hold");
            exp_irq(e0 + k, 1'b0, "dis_irq");
        end
        wr(B, 32'h9);
        run(4);
        wr(B, 32'h8);
        run(4);
        e1 = cyc + 1;
        exp_rd(e1 + 2, B + 8, 32'd10, "reen_load");
        exp_irq(e1 + 12, 1'b0, "reen_irq_early");
        exp_irq(e1 + 13, 1'b1, "reen_irq_rise");
        wr(B, 32'h9);
        run(13);
        wr(B, 32'h0);

        // PRESET=0 edge case
        wr(B + 4, 32'd0);
        e0 = cyc + 1;
        exp_irq(e0 + 3, 1'b0, "p0_early");
        exp_irq(e0 + 4, 1'b1, "p0_rise");
        wr(B, 32'h9);
        run(4);
        wr(B, 32'h0);

        // CTRL store on the INT edge: written EN survives, flag still set
        wr(B + 4, 32'd2);
        e0 = cyc + 1;
        exp_irq(e0 + 4, 1'b0, "col_early");
        exp_irq(e0 + 5, 1'b1, "col_irq");
        exp_rd(e0 + 5, B, 32'h9, "col_ctrl");
        exp_rd(e0 + 7, B + 8, 32'd2, "col_rearm");
        wr(B, 32'h9);
        run(4);
        wr(B, 32'h9);
        run(2);
        wr(B, 32'h0);
`else
        wr(B + 4, 32'd2);
        e0 = cyc + 1;
        exp_rd(e0 + 5, B + 8, 32'd2, "psc_hold");
        exp_rd(e0 + 6, B + 8, 32'd1, "psc_dec");
        exp_irq(e0 + 10, 1'b0, "psc_early");
        exp_irq(e0 + 11, 1'b1, "psc_rise");
        wr(B, 32'h9);
        run(11);
        wr(B, 32'h0);
`endif

        // Reset asserted mid-count
        wr(B + 4, 32'd5);
        e0 = cyc + 1;
`ifndef TIMER_PRESCALE_EN
        exp_rd(e0 + 4, B + 8, 32'd3, "rst_pre3");
`endif
        wr(B, 32'h9);
        run(4);
        reset = 1'b0;
        #1;
        addr = B + 8; #1; check("arst_count", dout, 32'd0);
        addr = B;     #1; check("arst_ctrl", dout, 32'd0);
        addr = B + 4; #1; check("arst_preset", dout, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        #2 reset = 1'b1;
        w = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            exp_rd(w + k, B + 8, 32'd0, "post_rst_count");
            exp_irq(w + k, 1'b0, "post_rst_irq");
        end
        exp_rd(w + 1, B, 32'd0, "post_rst_ctrl");
        wr(B + 4, 32'd4);
        run(3);

        run(2);
        check("sb_pending", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/timer_irq_unit.md
Name: timer_irq_unit

Overview:
- Memory-mapped countdown timer on the CPU data bus, alongside DM.
- Sole producer of the hardware-interrupt request consumed by CP0: its `irq` output feeds CP0's external interrupt input, which then raises `req` and redirects PC to the handler.
- Programmed by the processor with ordinary `sw`/`lw` to three word registers.

Parameters:
- BASE_ADDR, 32'h00007F00, word-aligned base of the 16-byte register window.
- WIDTH, 32, width of PRESET and COUNT.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  byte address from ALU result.
- we  input  1  store strobe; already gated by the CPU with no pending exception.
- din  input  32  store data (RD2).
- dout  output  32  read data, combinational.
- irq  output  1  interrupt request to CP0.

Behaviour:
- Hit: addr[31:4]==BASE_ADDR[31:4]. A write needs hit & we; addr[1:0] is ignored.
- Register map by addr[3:2]:
  - 0 CTRL: [0] EN, [2:1] MODE, [3] IM; other bits read 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes are ignored.
  - 3: reads 0.
- dout: register selected by addr[3:2] when hit, else 0. Same-cycle read, no latency.
- Writes take effect on the rising edge. A CTRL write also clears irq_flag on that edge.
- Reset (reset=0, asynchronous): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0. Reset asserted mid-count aborts immediately.
- FSM, one transition per edge:
  - IDLE: if EN → LOAD.
  - LOAD: COUNT<=PRESET → CNT.
  - CNT:
    - if !EN → IDLE, COUNT holds.
    - else if COUNT>1 → COUNT<=COUNT-1.
    - else → COUNT<=0, INT.
  - INT:
    - MODE 0 (one-shot): irq_flag<=1, EN<=0 → IDLE.
    - MODE 1 (auto-reload): irq_flag<=1 for exactly one cycle (cleared on the next edge) → LOAD.
    - MODE 2/3: treated as MODE 0.
- PRESET=0 or 1: CNT goes directly to INT on its first cycle.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- A CTRL write in the same cycle as the INT transition: the written CTRL value wins, including EN, over the FSM's EN clear. irq_flag set by INT wins over the clear caused by the write.
- Clearing EN while in INT: INT completes and the interrupt is still flagged.
- irq = IM & irq_flag, registered-source, glitch-free.
- Latency, write-enable edge E0 (MODE 0, PRESET=P≥2): irq rises at edge E0+P+3.
- MODE 1 period: P+2 cycles between irq pulses.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 4) and a free-running prescale counter reset in LOAD.
  - CNT decrements, or exits to INT, only on cycles where the prescale counter wraps; other CNT cycles hold COUNT.
  - Latency becomes E0+3+P·PRESCALE.
- Undefined: no prescaler; CNT advances every cycle.

Test Plan:
- Reset: drive reset=0 mid-count with COUNT=3 → COUNT, CTRL, irq read 0 immediately; state IDLE after release.
- One-shot: PRESET=5, CTRL=32'h9 → COUNT reads 5,4,3,2,1,0 on successive edges; irq=1 at E0+8 and stays; CTRL[0] reads 0; a CTRL write of 0 drops irq next edge.
- Auto-reload: PRESET=3, CTRL=32'hB → irq one-cycle pulses every 5 cycles, at E0+6 and E0+11.
- Mask and decode: CTRL=32'h1 (IM=0), PRESET=2 → irq stays 0. Store to BASE_ADDR+8 → COUNT unchanged. Read BASE_ADDR+12 → 0. Read BASE_ADDR+16 → 0.
- Disable mid-count: PRESET=10, enable, clear EN after COUNT=7 → COUNT holds 7 and no irq. Re-enable → reloads 10.
- Edge case: PRESET=0, CTRL=32'h9 → irq at E0+4. With TIMER_PRESCALE_EN and PRESCALE=4, PRESET=2 → irq at E0+11.
